// File: rtl/sensor_alarm_ctrl_if.sv
// rtl/sensor_alarm_ctrl_if.sv - sensor/buzzer bundle between pad ring and the alarm controller
interface sensor_alarm_ctrl_if #(
  parameter int NCH  = 3,
  parameter int ID_W = 2
);
  logic            ena;
  logic [NCH-1:0]  sensor;
  logic            ack;
  logic            latch_mode;
  logic [NCH-1:0]  buzzer;
  logic            active;
  logic [ID_W-1:0] alarm_id;
  logic [7:0]      alarm_count;

  modport master (
    output ena, sensor, ack, latch_mode,
    input  buzzer, active, alarm_id, alarm_count
  );

  modport slave (
    input  ena, sensor, ack, latch_mode,
    output buzzer, active, alarm_id, alarm_count
  );
endinterface

// File: rtl/sensor_alarm_ctrl.sv
// rtl/sensor_alarm_ctrl.sv - debounced priority sensor alarm with hold/latch, ack and event count
module sensor_alarm_ctrl #(
  parameter int NCH         = 3,
  parameter int DEB_CYCLES  = 8,
  parameter int HOLD_CYCLES = 32,
  parameter int ID_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sensor_alarm_ctrl_if.slave   bus
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
  localparam logic [CW:0]   DEB_HIT  = (CW+1)'(DEB_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, ALARM} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  buzzer_q, buzzer_d;
  logic            active_q, active_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      count_q, count_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [ID_W-1:0] cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [ID_W-1:0] c;
  logic [NCH-1:0]  onehot;
  logic [CW:0]     raw_cnt;
  logic [CW-1:0]   sat_cnt;
  logic            confirm;
  logic [7:0]      count_inc;

  // Lowest-numbered asserted sensor wins; encoded as 1+index so 0 means none.
  always_comb begin
    c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.sensor[i]) c = ID_W'(i + 1);
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      onehot[i] = (c == ID_W'(i + 1));
    end
  end

  // raw_cnt is one bit wider so a saturated run never compares equal to DEB again.
  always_comb begin
    raw_cnt = (CW+1)'(1);
    if (c == cand_q) raw_cnt = {1'b0, cnt_q} + (CW+1)'(1);
    sat_cnt = (raw_cnt > DEB_HIT) ? DEB_MAX : raw_cnt[CW-1:0];
  end

  assign confirm   = (c != '0) && (raw_cnt == DEB_HIT);
  assign count_inc = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    buzzer_d = buzzer_q;
    id_d     = id_q;
    count_d  = count_q;
    hold_d   = hold_q;
    cand_d   = c;
    cnt_d    = (c == '0) ? '0 : sat_cnt;

    case (state_q)
      IDLE: begin
        buzzer_d = '0;
        id_d     = '0;
        if (confirm) begin
          state_d  = ALARM;
          buzzer_d = onehot;
          id_d     = c;
          hold_d   = '0;
          count_d  = count_inc;
        end
      end
      ALARM: begin
        if (bus.ack) begin
          state_d  = IDLE;
          buzzer_d = '0;
          id_d     = '0;
          hold_d   = '0;
          cand_d   = '0;
          cnt_d    = '0;
        end else if (confirm && (c < id_q)) begin
          buzzer_d = onehot;
          id_d     = c;
          hold_d   = '0;
          count_d  = count_inc;
        end else if (!bus.latch_mode && (hold_q == HOLD_MAX)) begin
          state_d  = IDLE;
          buzzer_d = '0;
          id_d     = '0;
          hold_d   = '0;
          cand_d   = '0;
          cnt_d    = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        buzzer_d = '0;
        id_d     = '0;
      end
    endcase

    active_d = (state_d == ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buzzer_q <= '0;
      active_q <= 1'b0;
      id_q     <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else if (bus.ena) begin
      state_q  <= state_d;
      buzzer_q <= buzzer_d;
      active_q <= active_d;
      id_q     <= id_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.active      = active_q;
  assign bus.alarm_id    = id_q;
  assign bus.alarm_count = count_q;
endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb/tb_sensor_alarm_ctrl.sv - randomized and directed bench for sensor_alarm_ctrl against a behavioural model
module tb_sensor_alarm_ctrl;
  localparam int NCH  = 3;
  localparam int DEB  = 8;
  localparam int HOLD = 32;
  localparam int ID_W = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  sensor_alarm_ctrl_if #(.NCH(NCH), .ID_W(ID_W)) bus ();

  sensor_alarm_ctrl #(
    .NCH(NCH), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .ID_W(ID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: unbounded run length of the current lowest sensor, and elapsed alarm time.
  int m_run_ch, m_run_len, m_id, m_hold, m_count;
  bit m_alarm;

  task automatic model_reset();
    m_run_ch = 0; m_run_len = 0; m_id = 0; m_hold = 0; m_count = 0; m_alarm = 0;
  endtask

  task automatic model_raise(input int ch);
    m_alarm = 1; m_id = ch; m_hold = 0;
    if (m_count < 255) m_count++;
  endtask

  task automatic model_step(input bit e, input logic [2:0] s, input bit a, input bit l);
    int  ch, len;
    bit  conf, clr;
    if (!e) return;
    ch = 0;
    for (int i = 0; i < NCH; i++) if (s[i] && ch == 0) ch = i + 1;
    if (ch == 0) len = 0;
    else if (ch == m_run_ch) len = m_run_len + 1;
    else len = 1;
    conf = (ch != 0) && (len == DEB);
    m_run_ch = ch; m_run_len = len;
    clr = 0;
    if (!m_alarm) begin
      if (conf) model_raise(ch);
    end else if (a) clr = 1;
    else if (conf && ch < m_id) model_raise(ch);
    else if (!l && m_hold >= HOLD - 1) clr = 1;
    else m_hold++;
    if (clr) begin
      m_alarm = 0; m_id = 0; m_hold = 0; m_run_ch = 0; m_run_len = 0;
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [2:0] b;
    b = m_alarm ? 3'(1 << (m_id - 1)) : 3'b000;
    return {b, m_alarm, 2'(m_id), 8'(m_count)};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.buzzer, bus.active, bus.alarm_id, bus.alarm_count};
  endfunction

  task automatic cyc(input bit e, input logic [2:0] s, input bit a, input bit l);
    bus.ena = e; bus.sensor = s; bus.ack = a; bus.latch_mode = l;
    model_step(e, s, a, l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ena = 1'b1; bus.sensor = '0; bus.ack = 1'b0; bus.latch_mode = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.sensor = 3'b111; bus.ack = 1'b0; bus.latch_mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (act_vec() !== 14'd0) begin
      n_fail++; $display("FAIL reset: got %h want %h", act_vec(), 14'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= DEB; i++) begin
      cyc(1, 3'b010, 0, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL basic_deb edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.buzzer !== 3'b010 || bus.alarm_id !== 2'd2) begin
      n_fail++; $display("FAIL basic_rise: got buz %b id %0d want 010 2", bus.buzzer, bus.alarm_id);
    end
    for (int i = 1; i <= HOLD; i++) begin
      cyc(1, 3'b010, 0, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL basic_hold edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.buzzer !== 3'b000 || bus.alarm_count !== 8'd1) begin
      n_fail++; $display("FAIL basic_clear: got buz %b cnt %0d want 000 1", bus.buzzer, bus.alarm_count);
    end
    repeat (DEB) cyc(1, 3'b010, 0, 0);
    n_cmp++;
    if (bus.buzzer !== 3'b010 || bus.alarm_count !== 8'd2) begin
      n_fail++; $display("FAIL basic_realarm: got buz %b cnt %0d want 010 2", bus.buzzer, bus.alarm_count);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, (i == 8) ? 3'b000 : 3'b001, 0, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL glitch edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 15) begin
        n_cmp++;
        if (bus.buzzer !== 3'b000) begin
          n_fail++; $display("FAIL glitch_early: got %b want 000", bus.buzzer);
        end
      end
    end
    n_cmp++;
    if (bus.buzzer !== 3'b001) begin
      n_fail++; $display("FAIL glitch_rise: got %b want 001", bus.buzzer);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    repeat (DEB + 3) cyc(1, 3'b100, 0, 0);
    for (int i = 1; i <= DEB; i++) begin
      cyc(1, 3'b101, 0, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL preempt edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == DEB - 1) begin
        n_cmp++;
        if (bus.buzzer !== 3'b100) begin
          n_fail++; $display("FAIL preempt_old: got %b want 100", bus.buzzer);
        end
      end
    end
    n_cmp++;
    if (bus.buzzer !== 3'b001 || bus.alarm_id !== 2'd1 || bus.alarm_count !== 8'd2) begin
      n_fail++; $display("FAIL preempt_new: got buz %b id %0d cnt %0d want 001 1 2",
                         bus.buzzer, bus.alarm_id, bus.alarm_count);
    end
    for (int i = 1; i <= HOLD; i++) begin
      cyc(1, 3'b000, 0, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL preempt_hold edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    repeat (DEB) cyc(1, 3'b001, 0, 1);
    for (int i = 1; i <= DEB + 2; i++) begin
      cyc(1, 3'b100, 0, 1);
      n_cmp++;
      if (act_vec() !== exp_vec() || bus.buzzer !== 3'b001) begin
        n_fail++; $display("FAIL preempt_lower edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_latched();
    do_reset();
    repeat (DEB) cyc(1, 3'b010, 0, 1);
    for (int i = 1; i <= 110; i++) begin
      cyc(1, 3'b000, 0, 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL latched edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.buzzer !== 3'b010) begin
      n_fail++; $display("FAIL latched_on: got %b want 010", bus.buzzer);
    end
    cyc(1, 3'b000, 1, 1);
    n_cmp++;
    if (bus.buzzer !== 3'b000 || bus.active !== 1'b0 || bus.alarm_id !== 2'd0) begin
      n_fail++; $display("FAIL latched_ack: got buz %b act %b id %0d want 000 0 0",
                         bus.buzzer, bus.active, bus.alarm_id);
    end
    repeat (DEB) cyc(1, 3'b010, 0, 1);
    repeat (DEB - 1) cyc(1, 3'b001, 0, 1);
    cyc(1, 3'b001, 1, 1);
    n_cmp++;
    if (act_vec() !== exp_vec() || bus.buzzer !== 3'b000) begin
      n_fail++; $display("FAIL ack_wins: got %h want %h", act_vec(), exp_vec());
    end
    for (int i = 1; i <= DEB; i++) begin
      cyc(1, 3'b001, 0, 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ack_fresh edge %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ena();
    int on_time;
    do_reset();
    repeat (4) cyc(1, 3'b010, 0, 0);
    repeat (10) cyc(0, 3'b000, 1, 0);
    repeat (3) cyc(1, 3'b010, 0, 0);
    n_cmp++;
    if (bus.buzzer !== 3'b000) begin
      n_fail++; $display("FAIL ena_deb: got %b want 000", bus.buzzer);
    end
    cyc(1, 3'b010, 0, 0);
    n_cmp++;
    if (bus.buzzer !== 3'b010) begin
      n_fail++; $display("FAIL ena_rise: got %b want 010", bus.buzzer);
    end
    on_time = 0;
    for (int i = 0; i < 80 && bus.active === 1'b1; i++) begin
      if (i >= 10 && i < 20) cyc(0, 3'b000, 1, 0);
      else cyc(1, 3'b000, 0, 0);
      on_time++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ena_hold clk %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (on_time !== HOLD + 10) begin
      n_fail++; $display("FAIL ena_ontime: got %0d want %0d", on_time, HOLD + 10);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (DEB + 5) cyc(1, 3'b100, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.buzzer !== 3'b000 || bus.alarm_id !== 2'd0 || bus.alarm_count !== 8'd0 || bus.active !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", act_vec());
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      repeat (DEB) cyc(1, 3'b001, 0, 1);
      cyc(1, 3'b000, 1, 1);
    end
    n_cmp++;
    if (bus.alarm_count !== 8'd255 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL saturation: got cnt %0d want 255", bus.alarm_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] s;
    bit         l;
    int         dwell;
    do_reset();
    s = 3'b000; l = 1'b0; dwell = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dwell == 0) begin
        s = 3'($urandom_range(0, 7));
        dwell = $urandom_range(1, 20);
      end
      dwell--;
      if ($urandom_range(0, 99) == 0) l = ~l;
      cyc(($urandom_range(0, 9) != 0), s, ($urandom_range(0, 39) == 0), l);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.sensor = '0; bus.ack = 1'b0; bus.latch_mode = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_preempt();
    test_latched();
    test_ena();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
